// File: rtl/ahb_lite_pkg.sv
// ============================================================================
// ahb_lite_pkg : shared AHB-lite transfer/size/response codes and slave FSM.
// Revision 1.0
// ============================================================================
`default_nettype none

package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } ahb_state_t;

endpackage

`default_nettype wire

// File: rtl/ahb_byte_strobe.sv
// ============================================================================
// ahb_byte_strobe : HSIZE + low address bits -> little-endian byte strobe and
// alignment flag. Misaligned accesses get the force-aligned strobe.
// Revision 1.0
// ============================================================================
`default_nettype none

module ahb_byte_strobe
   import ahb_lite_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] strobe,
   output logic       aligned
);

   always_comb begin
      strobe  = 4'b1111;
      aligned = 1'b1;
      case (size)
         HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            strobe  = addr_lo[1] ? 4'b1100 : 4'b0011;
            aligned = ~addr_lo[0];
         end
         HSIZE_WORD: aligned = (addr_lo == 2'b00);
         // Oversized transfers keep the full-word strobe but are flagged.
         default:    aligned = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// ahb_sram_slave : AHB-lite responder in front of a word-organised SRAM with
// programmable wait states. Define AHB_SRAM_ERR_EN to ERROR misaligned/oversized.
// Revision 1.0
// ============================================================================
`default_nettype none

module ahb_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

   ahb_state_t            state;
   ahb_state_t            state_nxt;
   logic [3:0]            wait_cnt;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic                  write_q;
   logic [3:0]            strobe_q;
   logic [3:0]            strobe;
   logic                  aligned;
   logic                  illegal;
   logic                  accept;
   logic                  done;
   logic                  can_take;
   logic                  take;
   logic                  unused_ok;

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

   ahb_byte_strobe u_strobe (
      .size    (HSIZE),
      .addr_lo (HADDR[1:0]),
      .strobe  (strobe),
      .aligned (aligned)
   );

`ifdef AHB_SRAM_ERR_EN
   assign illegal   = ~aligned;
   assign unused_ok = ^{HADDR[31:DEPTH_LOG2+2], HTRANS[0]};
`else
   assign illegal   = 1'b0;
   assign unused_ok = ^{HADDR[31:DEPTH_LOG2+2], HTRANS[0], aligned};
`endif

   assign accept   = HSEL & HREADY & HTRANS[1];
   assign done     = (state == ST_DATA) && (wait_cnt == WAIT_LAST);
   // A new address phase is only ours to take once the previous data phase ends.
   assign can_take = (state == ST_IDLE) || (state == ST_ERR2) || done;
   assign take     = accept & can_take;

   always_comb begin
      state_nxt = state;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      HRDATA    = 32'h0;
      case (state)
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         ST_DATA: begin
            HREADYOUT = done;
            if (done && !write_q) HRDATA = mem[idx_q];
         end
         default: ;
      endcase
      if (take)          state_nxt = illegal ? ST_ERR1 : ST_DATA;
      else if (can_take) state_nxt = ST_IDLE;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         idx_q    <= '0;
         write_q  <= 1'b0;
         strobe_q <= 4'b0;
      end else begin
         state <= state_nxt;
         if (take) begin
            wait_cnt <= 4'd0;
            idx_q    <= HADDR[DEPTH_LOG2+1:2];
            write_q  <= HWRITE;
            strobe_q <= strobe;
         end else if (state == ST_DATA && !done) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   // SRAM array has no reset; an asserted reset suppresses the pending write.
   always_ff @(posedge HCLK) begin
      if (HRESETn && done && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (strobe_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// ============================================================================
// tb_ahb_sram_slave : directed AHB-lite traffic against two slaves (0 and 3
// wait states) checked every cycle against a transfer-level bus model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ahb_sram_slave;
   import ahb_lite_pkg::*;

   localparam int DEPTH_LOG2 = 10;
`ifdef AHB_SRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic        bus_sel = 1'b0;
   logic [31:0] HADDR   = 32'h0;
   logic [31:0] HWDATA  = 32'h0;
   logic [1:0]  HTRANS  = HTRANS_IDLE;
   logic        HWRITE  = 1'b0;
   logic [2:0]  HSIZE   = HSIZE_WORD;
   logic        sel     = 1'b0;   // 0 -> dut0 (no waits), 1 -> dut1 (3 waits)

   logic        ready0, resp0, ready1, resp1;
   logic [31:0] rdata0, rdata1;
   logic        act_ready, act_resp;
   logic [31:0] act_rdata;
   logic        hsel0, hsel1;

   int errors = 0;
   int checks = 0;

   assign act_ready = sel ? ready1 : ready0;
   assign act_resp  = sel ? resp1  : resp0;
   assign act_rdata = sel ? rdata1 : rdata0;
   assign hsel0     = bus_sel & ~sel;
   assign hsel1     = bus_sel & sel;

   always #5 HCLK = ~HCLK;

   ahb_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ready0),
      .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0));

   ahb_sram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(3)) dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(ready1),
      .HREADYOUT(ready1), .HRESP(resp1), .HRDATA(rdata1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transfer-level model ----------------
   logic [31:0] mm [int];
   bit          ph_valid = 1'b0;
   bit          ph_write, ph_err;
   int          ph_key, ph_age;
   logic [3:0]  ph_strb;
   int          m_n, m_off, m_base;
   logic [31:0] m_word;
   bit          m_rdy;

   function automatic bit m_ready();
      if (!ph_valid) return 1'b1;
      if (ph_err)    return ph_age == 1;
      return ph_age >= (sel ? 3 : 0);
   endfunction

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ph_valid = 1'b0;
      end else begin
         m_rdy = m_ready();
         if (ph_valid) begin
            if (m_rdy) begin
               if (!ph_err && ph_write) begin
                  m_word = mm.exists(ph_key) ? mm[ph_key] : 32'h0;
                  for (int i = 0; i < 4; i++)
                     if (ph_strb[i]) m_word[8*i +: 8] = HWDATA[8*i +: 8];
                  mm[ph_key] = m_word;
               end
               ph_valid = 1'b0;
            end else begin
               ph_age++;
            end
         end
         if (m_rdy && bus_sel && HTRANS[1]) begin
            m_n    = (HSIZE > 3'd2) ? 4 : (1 << HSIZE);
            m_off  = int'(HADDR[1:0]);
            m_base = m_off - (m_off % m_n);
            ph_err = ERR_EN && ((HSIZE > 3'd2) || (m_off % m_n) != 0);
            for (int i = 0; i < 4; i++) ph_strb[i] = (i >= m_base) && (i < m_base + m_n);
            ph_key   = (sel ? (1 << DEPTH_LOG2) : 0) + int'((HADDR >> 2) % (1 << DEPTH_LOG2));
            ph_write = HWRITE;
            ph_age   = 0;
            ph_valid = 1'b1;
         end
      end
   end

   always @(negedge HCLK) begin
      logic        e_rdy;
      logic        e_resp;
      logic [31:0] e_data;
      e_rdy  = m_ready();
      e_resp = ph_valid && ph_err;
      e_data = 32'h0;
      if (ph_valid && !ph_err && !ph_write && e_rdy)
         e_data = mm.exists(ph_key) ? mm[ph_key] : 32'hx;
      check("cyc_hreadyout", {31'b0, act_ready}, {31'b0, e_rdy});
      check("cyc_hresp",     {31'b0, act_resp},  {31'b0, e_resp});
      check("cyc_hrdata",    act_rdata, e_data);
   end

   // ---------------- master tasks ----------------
   task automatic addr_phase(input logic [31:0] a, input bit w, input logic [2:0] sz,
                             input logic [31:0] wd, output int waits);
      bit ok = 1'b0;
      bus_sel = 1'b1; HADDR = a; HTRANS = HTRANS_NONSEQ; HWRITE = w; HSIZE = sz;
      waits = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge HCLK);
         if (act_ready) ok = 1'b1; else waits++;
         @(posedge HCLK); #1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: addr %h never accepted", a);
      end
      HWDATA = wd;
      bus_sel = 1'b0; HTRANS = HTRANS_IDLE;
   endtask

   task automatic data_end(input bit chk, input string nm, input logic [31:0] exp,
                           output int waits);
      bit ok = 1'b0;
      bus_sel = 1'b0; HTRANS = HTRANS_IDLE; waits = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge HCLK);
         if (act_ready) begin
            ok = 1'b1;
            if (chk) check(nm, act_rdata, exp);
         end else waits++;
         @(posedge HCLK); #1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL data_timeout: %s never completed", nm);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2;
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_hreadyout", {31'b0, ready0}, 32'd1);
      check("rst_hresp",     {31'b0, resp0},  32'd0);
      check("rst_hrdata",    rdata1, 32'h0);
      @(posedge HCLK); #1;
      HRESETn = 1'b1;

      // idle and busy transfers: no data phase
      repeat (2) @(posedge HCLK);
      #1; bus_sel = 1'b1; HTRANS = HTRANS_BUSY;
      repeat (2) @(posedge HCLK);
      #1; bus_sel = 1'b0; HTRANS = HTRANS_IDLE;
      @(posedge HCLK); #1;

      // zero-wait slave: back-to-back write/read
      sel = 1'b0;
      addr_phase(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, w);
      addr_phase(32'h10, 1'b0, HSIZE_WORD, 32'h0, w);
      check("wr_rd_nowait", w, 0);
      data_end(1'b1, "rd_deadbeef", 32'hDEADBEEF, w);
      check("rd_nowait", w, 0);

      addr_phase(32'h13, 1'b1, HSIZE_BYTE, 32'hAA000000, w);
      addr_phase(32'h10, 1'b0, HSIZE_WORD, 32'h0, w);
      data_end(1'b1, "rd_byte_merge", 32'hAAADBEEF, w);

      addr_phase(32'h10, 1'b1, HSIZE_HALF, 32'h00001234, w);
      addr_phase(32'h13, 1'b0, HSIZE_BYTE, 32'h0, w);
      data_end(1'b1, "rd_half_merge", 32'hAAAD1234, w);
      check("model_word4", mm[4], 32'hAAAD1234);

      // aliasing modulo 4 KB
      addr_phase(32'h1000, 1'b1, HSIZE_WORD, 32'h5, w);
      addr_phase(32'h0, 1'b0, HSIZE_WORD, 32'h0, w);
      data_end(1'b1, "rd_alias", 32'h00000005, w);

      // misaligned word write
      addr_phase(32'h2, 1'b1, HSIZE_WORD, 32'h12345678, w);
      if (ERR_EN) begin
         @(negedge HCLK);
         check("err_phase1", {30'b0, act_ready, act_resp}, 32'b01);
         @(posedge HCLK); #1;
         @(negedge HCLK);
         check("err_phase2", {30'b0, act_ready, act_resp}, 32'b11);
         @(posedge HCLK); #1;
         addr_phase(32'h0, 1'b0, HSIZE_WORD, 32'h0, w);
         data_end(1'b1, "rd_after_err", 32'h00000005, w);
      end else begin
         addr_phase(32'h0, 1'b0, HSIZE_WORD, 32'h0, w);
         data_end(1'b1, "rd_forced_align", 32'h12345678, w);
      end

      // three-wait slave
      @(posedge HCLK); #1;
      sel = 1'b1;
      addr_phase(32'h20, 1'b1, HSIZE_WORD, 32'h11111111, w);
      data_end(1'b0, "wr_ws3", 32'h0, w);
      check("wr_ws3_waits", w, 3);
      addr_phase(32'h20, 1'b0, HSIZE_WORD, 32'h0, w);
      data_end(1'b1, "rd_ws3", 32'h11111111, w);
      check("rd_ws3_waits", w, 3);

      // pipelined NONSEQ held while the previous data phase waits
      addr_phase(32'h20, 1'b0, HSIZE_WORD, 32'h0, w);
      addr_phase(32'h24, 1'b1, HSIZE_WORD, 32'h0BADF00D, w2);
      check("held_nonseq_waits", w2, 3);
      addr_phase(32'h24, 1'b0, HSIZE_WORD, 32'h0, w2);
      data_end(1'b1, "rd_ws3_pipe", 32'h0BADF00D, w);

      // reset in the middle of a waited write
      addr_phase(32'h20, 1'b1, HSIZE_WORD, 32'hCAFEF00D, w);
      #2 HRESETn = 1'b0;
      #1;
      check("midrst_hreadyout", {31'b0, ready1}, 32'd1);
      check("midrst_hresp",     {31'b0, resp1},  32'd0);
      @(posedge HCLK); @(posedge HCLK); #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      addr_phase(32'h20, 1'b0, HSIZE_WORD, 32'h0, w);
      data_end(1'b1, "rd_after_midrst", 32'h11111111, w);

      repeat (2) @(posedge HCLK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
